seg7_scan_reader: RTL and testbench

//  Inverse of the board's BCD->7-segment path. Watches a multiplexed, active-low
//  7-seg display bus (segments + digit selects), debounces each digit's dwell,

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_pattern_decode.sv | 44 ++++
 rtl/seg7_scan_reader.sv | 211 +++++++++++++++++++++
 tb/tb_seg7_scan_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types, segment codes (abcdefg, active-high) and scan FSM states
// for the 7-segment display readback path.
package seg7_pkg;

   typedef logic [3:0] bcd_t;
   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0     = 7'h7E;
   localparam seg_t SEG_1     = 7'h30;
   localparam seg_t SEG_2     = 7'h6D;
   localparam seg_t SEG_3     = 7'h79;
   localparam seg_t SEG_4     = 7'h33;
   localparam seg_t SEG_5     = 7'h5B;
   localparam seg_t SEG_6     = 7'h5F;
   localparam seg_t SEG_7     = 7'h70;
   localparam seg_t SEG_8     = 7'h7F;
   localparam seg_t SEG_9     = 7'h7B;
   localparam seg_t SEG_BLANK = 7'h00;
   localparam seg_t SEG_A     = 7'h77;
   localparam seg_t SEG_B     = 7'h1F;
   localparam seg_t SEG_C     = 7'h4E;
   localparam seg_t SEG_D     = 7'h3D;
   localparam seg_t SEG_E     = 7'h4F;
   localparam seg_t SEG_F     = 7'h47;

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      COMMIT,
      HOLD
   } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment pattern -> BCD decoder. Hex letters A..F decode to
// 10..15 only when HEX_DECODE_EN is defined; otherwise they are illegal.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  seg_t pat_i,
   output bcd_t bcd_o,
   output logic blank_o,
   output logic illegal_o
);

`ifdef HEX_DECODE_EN
   localparam bit HexEn = 1'b1;
`else
   localparam bit HexEn = 1'b0;
`endif

   always_comb begin
      bcd_o     = '0;
      blank_o   = 1'b0;
      illegal_o = 1'b0;
      case (pat_i)
         SEG_0:     bcd_o = 4'd0;
         SEG_1:     bcd_o = 4'd1;
         SEG_2:     bcd_o = 4'd2;
         SEG_3:     bcd_o = 4'd3;
         SEG_4:     bcd_o = 4'd4;
         SEG_5:     bcd_o = 4'd5;
         SEG_6:     bcd_o = 4'd6;
         SEG_7:     bcd_o = 4'd7;
         SEG_8:     bcd_o = 4'd8;
         SEG_9:     bcd_o = 4'd9;
         SEG_BLANK: blank_o = 1'b1;
         SEG_A:     if (HexEn) bcd_o = 4'd10; else illegal_o = 1'b1;
         SEG_B:     if (HexEn) bcd_o = 4'd11; else illegal_o = 1'b1;
         SEG_C:     if (HexEn) bcd_o = 4'd12; else illegal_o = 1'b1;
         SEG_D:     if (HexEn) bcd_o = 4'd13; else illegal_o = 1'b1;
         SEG_E:     if (HexEn) bcd_o = 4'd14; else illegal_o = 1'b1;
         SEG_F:     if (HexEn) bcd_o = 4'd15; else illegal_o = 1'b1;
         default:   illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads back a multiplexed active-low 7-seg bus: debounces each digit dwell,
// decodes it and reports changes on a 1-entry update stream. Hex letters via HEX_DECODE_EN.
module seg7_scan_reader
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   dig_n,
   input  logic                    clear,
   output logic [4*NUM_DIGITS-1:0] bcd_flat,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    upd_valid,
   input  logic                    upd_ready,
   output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] upd_idx,
   output logic [3:0]              upd_bcd,
   output logic                    upd_blank,
   output logic                    err_illegal,
   output logic                    overrun
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_CYCLES);

   seg_t                  seg_s1_q, seg_s2_q;
   logic [NUM_DIGITS-1:0] dig_s1_q, dig_s2_q;
   seg_t                  samp_pat;
   logic [NUM_DIGITS-1:0] dig_act;
   logic                  samp_legal, samp_same;
   logic [IDX_W-1:0]      samp_idx;

   scan_state_t           state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   seg_t                  pat_q, pat_d;

   bcd_t                  dec_bcd;
   logic                  dec_blank, dec_illegal;

   logic [NUM_DIGITS-1:0][3:0] bcd_q, bcd_d;
   logic [NUM_DIGITS-1:0] dvld_q, dvld_d;
   logic                  err_q, err_d, ovr_q, ovr_d;
   logic                  uvld_q, uvld_d, ublank_q, ublank_d;
   logic [IDX_W-1:0]      uidx_q, uidx_d;
   bcd_t                  ubcd_q, ubcd_d;
   logic                  evt, evt_blank, pop;
   bcd_t                  evt_bcd;

   assign samp_pat   = ~seg_s2_q;
   assign dig_act    = ~dig_s2_q;
   assign samp_legal = $onehot(dig_act);

   always_comb begin
      samp_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (dig_act[i]) samp_idx = IDX_W'(i);
      end
   end

   assign samp_same = samp_legal && (samp_idx == idx_q) && (samp_pat == pat_q);

   // Dwell tracking: one commit per stable dwell, HOLD blocks repeats
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      pat_d   = pat_q;
      case (state_q)
         IDLE: begin
            if (samp_legal) begin
               state_d = TRACK;
               cnt_d   = CNT_W'(1);
               idx_d   = samp_idx;
               pat_d   = samp_pat;
            end
         end
         TRACK: begin
            if (!samp_legal) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (samp_same) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q + CNT_W'(1) == CNT_DONE) state_d = COMMIT;
            end else begin
               cnt_d = CNT_W'(1);
               idx_d = samp_idx;
               pat_d = samp_pat;
            end
         end
         COMMIT: state_d = HOLD;
         HOLD: begin
            if (!samp_legal) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (!samp_same) begin
               state_d = TRACK;
               cnt_d   = CNT_W'(1);
               idx_d   = samp_idx;
               pat_d   = samp_pat;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   seg7_pattern_decode u_decode (
      .pat_i     (pat_q),
      .bcd_o     (dec_bcd),
      .blank_o   (dec_blank),
      .illegal_o (dec_illegal)
   );

   always_comb begin
      bcd_d     = bcd_q;
      dvld_d    = dvld_q;
      err_d     = err_q;
      ovr_d     = ovr_q;
      uvld_d    = uvld_q;
      uidx_d    = uidx_q;
      ubcd_d    = ubcd_q;
      ublank_d  = ublank_q;
      evt       = 1'b0;
      evt_blank = 1'b0;
      evt_bcd   = '0;
      pop       = uvld_q && upd_ready;
      if (state_q == COMMIT) begin
         if (dec_illegal) begin
            err_d = 1'b1;
         end else if (dec_blank) begin
            evt           = dvld_q[idx_q];
            evt_blank     = 1'b1;
            dvld_d[idx_q] = 1'b0;
         end else begin
            evt           = !dvld_q[idx_q] || (bcd_q[idx_q] != dec_bcd);
            evt_bcd       = dec_bcd;
            bcd_d[idx_q]  = dec_bcd;
            dvld_d[idx_q] = 1'b1;
         end
      end
      // A pop frees the slot in the same cycle, so push+pop never overruns
      if (evt && (!uvld_q || pop)) begin
         uvld_d   = 1'b1;
         uidx_d   = idx_q;
         ubcd_d   = evt_bcd;
         ublank_d = evt_blank;
      end else if (pop) begin
         uvld_d = 1'b0;
      end
      if (evt && uvld_q && !pop) ovr_d = 1'b1;
      if (clear) begin
         dvld_d = '0;
         err_d  = 1'b0;
         ovr_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1_q <= '0;
         seg_s2_q <= '0;
         dig_s1_q <= '0;
         dig_s2_q <= '0;
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         pat_q    <= '0;
         bcd_q    <= '0;
         dvld_q   <= '0;
         err_q    <= 1'b0;
         ovr_q    <= 1'b0;
         uvld_q   <= 1'b0;
         uidx_q   <= '0;
         ubcd_q   <= '0;
         ublank_q <= 1'b0;
      end else begin
         seg_s1_q <= seg_n;
         seg_s2_q <= seg_s1_q;
         dig_s1_q <= dig_n;
         dig_s2_q <= dig_s1_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         pat_q    <= pat_d;
         bcd_q    <= bcd_d;
         dvld_q   <= dvld_d;
         err_q    <= err_d;
         ovr_q    <= ovr_d;
         uvld_q   <= uvld_d;
         uidx_q   <= uidx_d;
         ubcd_q   <= ubcd_d;
         ublank_q <= ublank_d;
      end
   end

   assign bcd_flat    = bcd_q;
   assign digit_valid = dvld_q;
   assign upd_valid   = uvld_q;
   assign upd_idx     = uidx_q;
   assign upd_bcd     = ubcd_q;
   assign upd_blank   = ublank_q;
   assign err_illegal = err_q;
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed self-checking bench for seg7_scan_reader (4 digits, 8-cycle debounce).
module tb_seg7_scan_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  seg_n = 7'h7F;
   logic [3:0]  dig_n = 4'hF;
   logic        clear = 1'b0;
   logic [15:0] bcd_flat;
   logic [3:0]  digit_valid;
   logic        upd_valid;
   logic        upd_ready = 1'b0;
   logic [1:0]  upd_idx;
   logic [3:0]  upd_bcd;
   logic        upd_blank;
   logic        err_illegal;
   logic        overrun;

   int n_checks = 0;
   int n_pass   = 0;
   int evt_cnt  = 0;
   int base;
   logic [1:0] last_idx = '0;
   logic [3:0] last_bcd = '0;

   seg7_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_n       (seg_n),
      .dig_n       (dig_n),
      .clear       (clear),
      .bcd_flat    (bcd_flat),
      .digit_valid (digit_valid),
      .upd_valid   (upd_valid),
      .upd_ready   (upd_ready),
      .upd_idx     (upd_idx),
      .upd_bcd     (upd_bcd),
      .upd_blank   (upd_blank),
      .err_illegal (err_illegal),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n && upd_valid && upd_ready) begin
         evt_cnt++;
         last_idx = upd_idx;
         last_bcd = upd_bcd;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      dig_n = 4'hF;
      seg_n = 7'h7F;
      clear = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Present digit select d with active-high pattern s for n clock edges.
   task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n);
      dig_n = d;
      seg_n = ~s;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bcd_flat, digit_valid, upd_valid, upd_idx, upd_bcd, upd_blank, err_illegal, overrun} !== '0)
         $display("FAIL reset_outputs: got bcd=%h vld=%b uv=%b err=%b ovr=%b, want all 0",
                  bcd_flat, digit_valid, upd_valid, err_illegal, overrun);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_single_commit();
      do_reset();
      upd_ready = 1'b1;
      base = evt_cnt;
      drive(4'b1110, 7'h79, 10);
      n_checks++;
      if ({digit_valid, upd_valid} !== 5'b0)
         $display("FAIL early_commit: vld=%b uv=%b after edge 9, want 0", digit_valid, upd_valid);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({bcd_flat[3:0], digit_valid, upd_valid, upd_idx, upd_bcd, upd_blank} !== {4'd3, 4'b0001, 1'b1, 2'd0, 4'd3, 1'b0})
         $display("FAIL commit_edge10: bcd=%h vld=%b uv=%b idx=%0d ubcd=%0d blank=%b, want 3/0001/1/0/3/0",
                  bcd_flat[3:0], digit_valid, upd_valid, upd_idx, upd_bcd, upd_blank);
      else n_pass++;
      repeat (12) @(negedge clk);
      n_checks++;
      if ({upd_valid, evt_cnt - base, last_bcd} !== {1'b0, 32'd1, 4'd3})
         $display("FAIL single_event: uv=%b events=%0d last_bcd=%0d, want 0/1/3",
                  upd_valid, evt_cnt - base, last_bcd);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      do_reset();
      upd_ready = 1'b1;
      base = evt_cnt;
      for (int r = 0; r < 3; r++) begin
         drive(4'b1110, 7'h5B, 12);
         drive(4'b1101, 7'h7E, 12);
         drive(4'b1011, 7'h70, 12);
         drive(4'b0111, 7'h7B, 12);
      end
      drive(4'b1111, 7'h00, 4);
      n_checks++;
      if (bcd_flat !== 16'h9705) $display("FAIL rr_bcd: got %h want 9705", bcd_flat);
      else n_pass++;
      n_checks++;
      if (digit_valid !== 4'b1111) $display("FAIL rr_valid: got %b want 1111", digit_valid);
      else n_pass++;
      n_checks++;
      if ({evt_cnt - base, last_idx, last_bcd} !== {32'd4, 2'd3, 4'd9})
         $display("FAIL rr_events: events=%0d last idx=%0d bcd=%0d, want 4/3/9", evt_cnt - base, last_idx, last_bcd);
      else n_pass++;
   endtask

   task automatic test_unstable();
      do_reset();
      upd_ready = 1'b1;
      drive(4'b1101, 7'h6D, 12);
      drive(4'b1111, 7'h00, 2);
      base = evt_cnt;
      for (int k = 0; k < 6; k++) drive(4'b1110, (k % 2 == 1) ? 7'h30 : 7'h7E, 4);
      drive(4'b1100, 7'h7E, 20);
      drive(4'b1111, 7'h00, 4);
      n_checks++;
      if ({bcd_flat, digit_valid, err_illegal} !== {16'h0020, 4'b0010, 1'b0})
         $display("FAIL unstable_state: bcd=%h vld=%b err=%b, want 0020/0010/0", bcd_flat, digit_valid, err_illegal);
      else n_pass++;
      n_checks++;
      if (evt_cnt - base !== 0) $display("FAIL unstable_events: got %0d want 0", evt_cnt - base);
      else n_pass++;
   endtask

   task automatic test_illegal();
      do_reset();
      upd_ready = 1'b1;
      base = evt_cnt;
      drive(4'b1101, 7'h77, 12);
      drive(4'b1111, 7'h00, 2);
`ifdef HEX_DECODE_EN
      n_checks++;
      if ({bcd_flat, digit_valid, err_illegal, evt_cnt - base} !== {16'h00A0, 4'b0010, 1'b0, 32'd1})
         $display("FAIL hex_a: bcd=%h vld=%b err=%b events=%0d, want 00A0/0010/0/1",
                  bcd_flat, digit_valid, err_illegal, evt_cnt - base);
      else n_pass++;
`else
      n_checks++;
      if ({bcd_flat, digit_valid, err_illegal, evt_cnt - base} !== {16'h0000, 4'b0000, 1'b1, 32'd0})
         $display("FAIL illegal_a: bcd=%h vld=%b err=%b events=%0d, want 0000/0000/1/0",
                  bcd_flat, digit_valid, err_illegal, evt_cnt - base);
      else n_pass++;
`endif
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n_checks++;
      if ({err_illegal, digit_valid} !== 5'b0)
         $display("FAIL clear_flags: err=%b vld=%b, want 0/0000", err_illegal, digit_valid);
      else n_pass++;
   endtask

   task automatic test_overrun();
      do_reset();
      upd_ready = 1'b0;
      base = evt_cnt;
      drive(4'b1110, 7'h33, 12);
      n_checks++;
      if ({upd_valid, upd_idx, upd_bcd, overrun, digit_valid} !== {1'b1, 2'd0, 4'd4, 1'b0, 4'b0001})
         $display("FAIL first_push: uv=%b idx=%0d bcd=%0d ovr=%b vld=%b, want 1/0/4/0/0001",
                  upd_valid, upd_idx, upd_bcd, overrun, digit_valid);
      else n_pass++;
      drive(4'b1101, 7'h7F, 12);
      n_checks++;
      if ({upd_valid, upd_idx, upd_bcd, overrun, bcd_flat[7:4], digit_valid} !== {1'b1, 2'd0, 4'd4, 1'b1, 4'd8, 4'b0011})
         $display("FAIL overrun_hold: uv=%b idx=%0d bcd=%0d ovr=%b d1=%0d vld=%b, want 1/0/4/1/8/0011",
                  upd_valid, upd_idx, upd_bcd, overrun, bcd_flat[7:4], digit_valid);
      else n_pass++;
      dig_n = 4'hF;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n_checks++;
      if ({overrun, digit_valid, upd_valid, upd_idx, upd_bcd} !== {1'b0, 4'b0000, 1'b1, 2'd0, 4'd4})
         $display("FAIL clear_keeps_event: ovr=%b vld=%b uv=%b idx=%0d bcd=%0d, want 0/0000/1/0/4",
                  overrun, digit_valid, upd_valid, upd_idx, upd_bcd);
      else n_pass++;
      upd_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({upd_valid, evt_cnt - base, last_idx, last_bcd} !== {1'b0, 32'd1, 2'd0, 4'd4})
         $display("FAIL pop: uv=%b events=%0d idx=%0d bcd=%0d, want 0/1/0/4",
                  upd_valid, evt_cnt - base, last_idx, last_bcd);
      else n_pass++;
   endtask

   task automatic test_async_reset_blank();
      do_reset();
      upd_ready = 1'b1;
      drive(4'b1011, 7'h5F, 12);
      n_checks++;
      if ({bcd_flat, digit_valid} !== {16'h0600, 4'b0100})
         $display("FAIL pre_reset: bcd=%h vld=%b, want 0600/0100", bcd_flat, digit_valid);
      else n_pass++;
      drive(4'b0111, 7'h79, 5);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bcd_flat, digit_valid, upd_valid, err_illegal, overrun} !== '0)
         $display("FAIL async_reset: bcd=%h vld=%b uv=%b, want all 0", bcd_flat, digit_valid, upd_valid);
      else n_pass++;
      @(negedge clk);
      dig_n = 4'hF;
      rst_n = 1'b1;
      drive(4'b1011, 7'h5F, 12);
      upd_ready = 1'b0;
      drive(4'b1011, 7'h00, 12);
      n_checks++;
      if ({digit_valid, bcd_flat, upd_valid, upd_blank, upd_idx, upd_bcd} !== {4'b0000, 16'h0600, 1'b1, 1'b1, 2'd2, 4'd0})
         $display("FAIL blank_commit: vld=%b bcd=%h uv=%b blank=%b idx=%0d ubcd=%0d, want 0000/0600/1/1/2/0",
                  digit_valid, bcd_flat, upd_valid, upd_blank, upd_idx, upd_bcd);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_commit();
      test_round_robin();
      test_unstable();
      test_illegal();
      test_overrun();
      test_async_reset_blank();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
